// File: rtl/gemv_prealign_fold.sv
// Folded GEMV pre-alignment: per-row max exponent and mantissa right-align, LANES rows per beat.
// Define PREALIGN_ROUND_EN for round-half-away alignment; truncation otherwise.
module gemv_prealign_fold #(
  parameter int EXP_WIDTH        = 8,
  parameter int MANTISSA_WIDTH   = 7,
  parameter int FP_WIDTH         = 1 + EXP_WIDTH + MANTISSA_WIDTH,
  parameter int PARALLEL_ROW     = 32,
  parameter int MACRO_DATA_WIDTH = 16,
  parameter int LANES            = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [PARALLEL_ROW*MACRO_DATA_WIDTH*FP_WIDTH-1:0] data_in,
  input  logic data_in_vld,
  output logic data_in_rdy,
  output logic [PARALLEL_ROW*MACRO_DATA_WIDTH*(MANTISSA_WIDTH+2)-1:0] mantissa_plus_aligned,
  output logic [PARALLEL_ROW*EXP_WIDTH-1:0] exp_max,
  output logic pre_aligned_vld,
  input  logic pre_aligned_rdy,
  output logic busy
);

  localparam int MDW  = MACRO_DATA_WIDTH;
  localparam int FOLD = PARALLEL_ROW / LANES;
  localparam int OW   = MANTISSA_WIDTH + 2;
  localparam int MW   = MANTISSA_WIDTH + 1;
  localparam int CW   = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int SI   = LANES * MDW * FP_WIDTH;
  localparam int SO   = LANES * MDW * OW;
  localparam int SE   = LANES * EXP_WIDTH;

  if (PARALLEL_ROW % LANES != 0) begin : g_bad_lanes
    $error("PARALLEL_ROW must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [PARALLEL_ROW*MDW*FP_WIDTH-1:0] in_reg;
  logic [PARALLEL_ROW*MDW*OW-1:0] out_reg;
  logic [PARALLEL_ROW*EXP_WIDTH-1:0] exp_reg;
  logic vld_q;
  logic busy_q;

  logic [SI-1:0] slice_in;
  logic [SO-1:0] slice_out;
  logic [SE-1:0] slice_exp;
  logic [EXP_WIDTH-1:0] lane_max [LANES];

  function automatic logic [OW-1:0] align(
    input logic [FP_WIDTH-1:0]  x,
    input logic [EXP_WIDTH-1:0] emax
  );
    logic [EXP_WIDTH-1:0] e;
    logic [EXP_WIDTH-1:0] s;
    logic [MW-1:0] mag;
    logic [MW-1:0] q;
`ifdef PREALIGN_ROUND_EN
    logic [MW-1:0] rb;
`endif
    e   = x[FP_WIDTH-2 -: EXP_WIDTH];
    mag = (e != '0) ? {1'b1, x[MANTISSA_WIDTH-1:0]} : '0;
    s   = emax - e;
    if (s >= EXP_WIDTH'(MW + 1)) begin
      q = '0;
    end else begin
      q = mag >> s;
`ifdef PREALIGN_ROUND_EN
      // max result is 2^M, so the increment never carries out
      rb = mag >> (s - 1'b1);
      if (s != '0) q = q + MW'(rb[0]);
`endif
    end
    return {x[FP_WIDTH-1], q};
  endfunction

  assign slice_in = in_reg[int'(cnt)*SI +: SI];

  always_comb begin
    slice_out = '0;
    slice_exp = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_max[l] = '0;
      for (int j = 0; j < MDW; j++) begin
        if (slice_in[(l*MDW+j)*FP_WIDTH+MANTISSA_WIDTH +: EXP_WIDTH] > lane_max[l])
          lane_max[l] = slice_in[(l*MDW+j)*FP_WIDTH+MANTISSA_WIDTH +: EXP_WIDTH];
      end
      slice_exp[l*EXP_WIDTH +: EXP_WIDTH] = lane_max[l];
      for (int j = 0; j < MDW; j++) begin
        slice_out[(l*MDW+j)*OW +: OW] =
          align(slice_in[(l*MDW+j)*FP_WIDTH +: FP_WIDTH], lane_max[l]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      in_reg  <= '0;
      out_reg <= '0;
      exp_reg <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_in_vld) begin
            in_reg <= data_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          out_reg[int'(cnt)*SO +: SO] <= slice_out;
          exp_reg[int'(cnt)*SE +: SE] <= slice_exp;
          if (cnt == CW'(FOLD - 1)) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            vld_q  <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (pre_aligned_rdy) begin
            vld_q <= 1'b0;
            if (data_in_vld) begin
              in_reg <= data_in;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_in_rdy = (state == IDLE) || ((state == DONE) && pre_aligned_rdy);
  assign pre_aligned_vld = vld_q;
  assign busy = busy_q;
  assign mantissa_plus_aligned = out_reg;
  assign exp_max = exp_reg;

endmodule

// File: tb/tb_gemv_prealign_fold.sv
// Scoreboard bench for gemv_prealign_fold (4 rows x 4 elems, 2 lanes).
// Honours PREALIGN_ROUND_EN for the expected rounding mode.
`timescale 1ns/1ps
module tb_gemv_prealign_fold;

  localparam int PR  = 4;
  localparam int MDW = 4;
  localparam int LN  = 2;
  localparam int EW  = 8;
  localparam int MW  = 7;
  localparam int FW  = 16;
  localparam int OW  = 9;
  localparam int IW  = PR * MDW * FW;
  localparam int XW  = PR * MDW * OW;
  localparam int EXW = PR * EW;
`ifdef PREALIGN_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IW-1:0] data_in = '0;
  logic data_in_vld = 1'b0;
  logic data_in_rdy;
  logic [XW-1:0] mantissa_plus_aligned;
  logic [EXW-1:0] exp_max;
  logic pre_aligned_vld;
  logic pre_aligned_rdy = 1'b1;
  logic busy;

  typedef struct packed {
    logic [EXW-1:0] e;
    logic [XW-1:0]  m;
  } res_t;

  res_t sb[$];
  res_t exp_r;
  res_t hold_r;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_out = -1;
  bit tp_on = 1'b0;

  gemv_prealign_fold #(
    .EXP_WIDTH(EW), .MANTISSA_WIDTH(MW), .FP_WIDTH(FW),
    .PARALLEL_ROW(PR), .MACRO_DATA_WIDTH(MDW), .LANES(LN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_vld(data_in_vld),
    .data_in_rdy(data_in_rdy),
    .mantissa_plus_aligned(mantissa_plus_aligned),
    .exp_max(exp_max),
    .pre_aligned_vld(pre_aligned_vld),
    .pre_aligned_rdy(pre_aligned_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic [IW-1:0] v);
    res_t r;
    int mx, e, m, mag, s, o;
    logic [FW-1:0] x;
    r = '0;
    for (int row = 0; row < PR; row++) begin
      mx = 0;
      for (int j = 0; j < MDW; j++) begin
        x = v[(row*MDW+j)*FW +: FW];
        e = int'(x[14:7]);
        if (e > mx) mx = e;
      end
      r.e[row*EW +: EW] = EW'(mx);
      for (int j = 0; j < MDW; j++) begin
        x = v[(row*MDW+j)*FW +: FW];
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        mag = (e == 0) ? 0 : 128 + m;
        s = mx - e;
        if (s >= 9) o = 0;
        else if (RND && s > 0) o = (mag + (1 << (s - 1))) >> s;
        else o = mag >> s;
        r.m[(row*MDW+j)*OW +: OW] = {x[15], 8'(o)};
      end
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rnd_vec();
    logic [IW-1:0] v;
    logic [7:0] e;
    v = '0;
    for (int k = 0; k < PR*MDW; k++) begin
      e = ($urandom % 8 == 0) ? 8'd0 : 8'(118 + $urandom % 14);
      v[k*FW +: FW] = {1'($urandom), e, 7'($urandom)};
    end
    return v;
  endfunction

  // scoreboard: push on input handshake, pop on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (pre_aligned_vld && pre_aligned_rdy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_r = sb.pop_front();
          chk("sb_exp_max", exp_max, exp_r.e);
          chk("sb_aligned", mantissa_plus_aligned, exp_r.m);
        end
        if (tp_on) begin
          if (last_out >= 0) chk("throughput", cyc - last_out, 3);
          last_out = cyc;
        end
      end
      if (data_in_vld && data_in_rdy) sb.push_back(model(data_in));
    end
  end

  task automatic send(input logic [IW-1:0] v, input bit keep);
    int n;
    n = 0;
    data_in = v;
    data_in_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!data_in_rdy && n < 50);
    if (!data_in_rdy) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) data_in_vld = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!pre_aligned_vld && n < 20);
    chk(tag, pre_aligned_vld, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] v;
    repeat (2) @(negedge clk);
    chk("rst_vld", pre_aligned_vld, 0);
    chk("rst_rdy", data_in_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_exp", exp_max, 0);
    chk("rst_out", mantissa_plus_aligned, 0);
    @(posedge clk); #1 rst = 1'b0;

    // basic alignment and latency
    v = rnd_vec();
    v[0*FW +: FW] = 16'h3F80;
    v[1*FW +: FW] = 16'h3F00;
    v[2*FW +: FW] = 16'hC040;
    v[3*FW +: FW] = 16'h0000;
    send(v, 1'b0);
    @(negedge clk);
    chk("lat_e0_vld", pre_aligned_vld, 0);
    chk("lat_e0_busy", busy, 1);
    chk("busy_rdy", data_in_rdy, 0);
    @(negedge clk);
    chk("lat_e1_vld", pre_aligned_vld, 0);
    @(negedge clk);
    chk("lat_e2_vld", pre_aligned_vld, 1);
    chk("lat_e2_busy", busy, 0);
    chk("t1_exp", exp_max[0 +: 8], 8'h80);
    chk("t1_el0", mantissa_plus_aligned[0 +: 9], 9'h040);
    chk("t1_el1", mantissa_plus_aligned[9 +: 9], 9'h020);
    chk("t1_el2", mantissa_plus_aligned[18 +: 9], 9'h1C0);
    chk("t1_el3", mantissa_plus_aligned[27 +: 9], 9'h000);
    @(posedge clk); #1;

    // rounding and far-shift boundaries
    v = rnd_vec();
    v[0*FW +: FW] = 16'h3F81;
    v[1*FW +: FW] = 16'h4000;
    v[2*FW +: FW] = 16'h3B80;
    v[3*FW +: FW] = 16'h0000;
    v[4*FW +: FW] = 16'h4000;
    v[5*FW +: FW] = 16'h3C00;
    v[6*FW +: FW] = 16'hBC7F;
    v[7*FW +: FW] = 16'h3FFF;
    send(v, 1'b0);
    wait_vld("t2_vld");
    chk("t2_round", mantissa_plus_aligned[0 +: 9], RND ? 9'h041 : 9'h040);
    chk("t2_s9", mantissa_plus_aligned[18 +: 9], 9'h000);
    chk("t2_s8", mantissa_plus_aligned[45 +: 9], RND ? 9'h001 : 9'h000);
    @(posedge clk); #1;

    // sink stall then back-to-back accept
    pre_aligned_rdy = 1'b0;
    v = rnd_vec();
    hold_r = model(v);
    send(v, 1'b0);
    wait_vld("t3_vld");
    data_in = rnd_vec();
    data_in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_vld", pre_aligned_vld, 1);
      chk("stall_rdy", data_in_rdy, 0);
      chk("stall_exp", exp_max, hold_r.e);
      chk("stall_out", mantissa_plus_aligned, hold_r.m);
    end
    @(posedge clk); #1 pre_aligned_rdy = 1'b1;
    @(negedge clk);
    chk("b2b_rdy", data_in_rdy, 1);
    @(posedge clk); #1 data_in_vld = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    wait_vld("t3b_vld");
    @(posedge clk); #1;

    // continuous stream
    tp_on = 1'b1;
    last_out = -1;
    for (int k = 0; k < 10; k++) send(rnd_vec(), 1'b1);
    data_in_vld = 1'b0;
    wait_vld("stream_vld");
    @(posedge clk); #1 tp_on = 1'b0;

    // reset during second beat
    send(rnd_vec(), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_vld", pre_aligned_vld, 0);
    chk("mid_rst_exp", exp_max, 0);
    chk("mid_rst_out", mantissa_plus_aligned, 0);
    chk("mid_rst_rdy", data_in_rdy, 1);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    send(rnd_vec(), 1'b0);
    wait_vld("post_rst_vld");
    @(posedge clk); #1;

    // zero rows and saturated exponents with mixed signs
    v = '0;
    v[0*FW +: FW] = 16'h8000;
    v[4*FW +: FW] = 16'h7F00;
    v[5*FW +: FW] = 16'hFF7F;
    v[6*FW +: FW] = 16'h7F55;
    v[7*FW +: FW] = 16'hFF01;
    send(v, 1'b0);
    wait_vld("t6_vld");
    chk("zero_exp", exp_max[0 +: 8], 8'h00);
    chk("neg_zero", mantissa_plus_aligned[0 +: 9], 9'h100);
    chk("fe_exp", exp_max[8 +: 8], 8'hFE);
    chk("fe_neg", mantissa_plus_aligned[45 +: 9], 9'h1FF);
    chk("fe_pos", mantissa_plus_aligned[54 +: 9], 9'h0D5);
    chk("zero_rows", {exp_max[16 +: 16]}, 0);
    @(posedge clk); #1;

    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
